uart_rx_byte: RTL

- Serial-to-parallel UART receiver (8N1) that sits directly upstream of the team's 8-bit enable-loaded register.
- Recovers bytes from an asynchronous serial line.
- Presents each byte on an 8-bit bus with a one-cycle valid strobe, wired straight to the register's data input and load enable.
- Also flags framing errors and reports a busy status.

---
 rtl/uart_rx_byte.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM,
// registered byte output with one-cycle valid / framing-error strobes.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_ferr, w_ferr_nxt;
  logic             r_rx_meta, r_rx_s;

  // Synchroniser resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the pre-edge values,
      // giving a true two-stage chain instead of a single collapsed flop.
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) w_state_nxt = START;
      end
      START: begin
        // A line that is high again at mid-start was only a glitch.
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = r_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = r_rx_s;
          if (r_bit_idx == 3'd7) w_state_nxt = STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
        end
      end
      STOP: begin
        // Leave at mid-stop so a following start bit is caught without an idle gap.
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          if (r_rx_s) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_ferr_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign frame_error = r_ferr;
  assign busy        = (r_state != IDLE);

endmodule
